id_scan_arbiter: RTL and testbench
==================================

Name: id_scan_arbiter

Overview:
- Shares one identifier-recognizer FSM between two character-stream sources.
- Streams are handled token by token. A token is a run of characters ended by a terminator: any byte outside [0-9A-Za-z].
- Round-robin arbitration at token granularity. The grant is held until the terminator of the current token has been transferred.
- Drives the recognizer's char/enable inputs, samples its out flag at the terminator, and reports per-token results plus saturating per-source match counters.

Parameters:
- CNT_W, 8: width of each per-source match counter.
- TIMEOUT, 16: stall cycles allowed mid-token before abort (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- src0_valid  input  1  source 0 has a char.
- src0_char  input  8  source 0 ASCII char.
- src0_ready  output  1  source 0 char accepted this cycle if valid.
- src1_valid  input  1  source 1 has a char.
- src1_char  input  8  source 1 ASCII char.
- src1_ready  output  1  source 1 char accepted this cycle if valid.
- fsm_char  output  8  char to the shared recognizer.
- fsm_en  output  1  recognizer advances on this clk edge only when 1.
- fsm_out  input  1  recognizer result (registered): reflects chars accepted before the current cycle.
- tok_done  output  1  one-cycle pulse: token finished.
- tok_src  output  1  source of the finished token.
- tok_match  output  1  token was a valid identifier.
- tok_abort  output  1  token aborted by timeout.
- match_cnt0  output  CNT_W  source 0 match count.
- match_cnt1  output  CNT_W  source 1 match count.

Behaviour:
- Reset values: state IDLE, last_grant=1 (source 0 wins the first tie), stall counter 0.
- Reset values of outputs: tok_done, tok_src, tok_match, tok_abort all 0; counters 0; both readys 0; fsm_en 0; fsm_char 8'h00.
- Reset is honoured in any state, including mid-token. A partial token is discarded with no tok_done. The recognizer is reset by the same reset line.
- States: IDLE, BUSY, FLUSH. FLUSH is reachable only with the optional feature.
- IDLE:
  - Readys are 0.
  - Only src0_valid=1: grant 0. Only src1_valid=1: grant 1. Both valid: grant the source != last_grant.
  - On a grant, go to BUSY next cycle and set last_grant to the granted source. Otherwise stay in IDLE.
- BUSY:
  - srcN_ready=1 only for the granted source; the other ready is 0.
  - Transfer = granted valid & ready.
  - fsm_char = granted char (combinational); fsm_en = transfer.
  - On transfer of a terminator in cycle T:
    - Sample fsm_out in T as the token result.
    - At T+1: tok_done=1, tok_src=grant, tok_match=sampled value, tok_abort=0; state goes to IDLE.
    - The terminator itself resets the recognizer.
  - Non-terminator transfer: stay in BUSY.
  - No valid: stay in BUSY with fsm_en=0, so recognizer state is held.
- Token latency: minimum 1 bubble (IDLE) between consecutive tokens. The next grant is decided in T+1 and ready is high again in T+2.
- A lone terminator (empty token) is still a token: tok_done with tok_match = current fsm_out (0 after reset or after a terminator).
- Counters: at the tok_done cycle with tok_match=1, increment match_cnt[tok_src]. Saturate at 2^CNT_W-1, no wrap.
- tok_src, tok_match and tok_abort hold their values between tok_done pulses.

Optional Feature:
- Macro: ID_SCAN_TIMEOUT_EN.
- Defined:
  - Stall counter clears on every transfer and on entry to BUSY. It increments for each BUSY cycle without a transfer.
  - When it reaches TIMEOUT, go to FLUSH.
  - FLUSH (1 cycle): readys 0, fsm_char=8'h00, fsm_en=1. This forces the recognizer to its idle state.
  - Next cycle: tok_done=1, tok_src=grant, tok_match=0, tok_abort=1; state goes to IDLE. Counters unchanged.
- Undefined: no stall counter, no FLUSH state. BUSY waits indefinitely; tok_abort is tied 0.

Test Plan:
- Reset, then src0 sends "abcd1234/" back-to-back -> src0_ready high from the 2nd cycle after valid; fsm_en follows each transfer; tok_done one cycle after '/'; tok_src=0, tok_match=1, match_cnt0=1, match_cnt1=0.
- src1 sends "1ab/" -> tok_done with tok_src=1, tok_match=0; match_cnt1 stays 0.
- After reset, both valid continuously, each with "ab1/" -> tokens served 0,1,0,1; the ungranted ready stays 0 for the whole other token; both counters = 2 after four tokens.
- CNT_W=2, src0 sends "x9/" five times -> match_cnt0 = 1,2,3,3,3 (saturates).
- src0 sends "ab", valid drops 5 cycles, then "1/" -> fsm_en=0 during the gap; tok_match=1. Also assert reset after "ab" -> all outputs 0, no tok_done, state IDLE.
- With ID_SCAN_TIMEOUT_EN and TIMEOUT=16: src1 sends "ab" then idles -> 16 stall cycles, FLUSH cycle with fsm_char=8'h00 and fsm_en=1, then tok_done with tok_abort=1 and tok_match=0; the grant is released and a waiting src0 is served next.

Source files
------------

// File: rtl/id_scan_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : id_scan_arbiter
// Purpose  : Round-robin, token-granular sharing of one identifier recognizer
//            between two character streams. Optional mid-token stall abort is
//            enabled by defining ID_SCAN_TIMEOUT_EN.
// Revision : 1.0
// =============================================================================
module id_scan_arbiter #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src0_valid,
    input  logic [7:0]       src0_char,
    output logic             src0_ready,
    input  logic             src1_valid,
    input  logic [7:0]       src1_char,
    output logic             src1_ready,
    output logic [7:0]       fsm_char,
    output logic             fsm_en,
    input  logic             fsm_out,
    output logic             tok_done,
    output logic             tok_src,
    output logic             tok_match,
    output logic             tok_abort,
    output logic [CNT_W-1:0] match_cnt0,
    output logic [CNT_W-1:0] match_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic             tok_done_q, tok_done_d;
    logic             tok_src_q, tok_src_d;
    logic             tok_match_q, tok_match_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

`ifdef ID_SCAN_TIMEOUT_EN
    localparam int                   C_STALL_W    = $clog2(TIMEOUT + 1);
    localparam logic [C_STALL_W-1:0] C_STALL_LAST = C_STALL_W'(TIMEOUT - 1);

    logic [C_STALL_W-1:0] stall_q, stall_d;
    logic                 tok_abort_q, tok_abort_d;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    logic       w_busy;
    logic       w_gnt_valid;
    logic [7:0] w_gnt_char;
    logic       w_xfer;
    logic       w_term;
    logic       w_pick;

    function automatic logic is_alnum(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h5A)) ||
               ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    assign w_busy      = (state_q == ST_BUSY);
    assign w_gnt_valid = grant_q ? src1_valid : src0_valid;
    assign w_gnt_char  = grant_q ? src1_char  : src0_char;
    assign w_xfer      = w_busy & w_gnt_valid;
    assign w_term      = ~is_alnum(w_gnt_char);

    // On a tie the source that did not win last time is served.
    assign w_pick      = (src0_valid & src1_valid) ? ~last_grant_q : src1_valid;

    assign src0_ready  = w_busy & ~grant_q;
    assign src1_ready  = w_busy &  grant_q;
    assign fsm_char    = w_busy ? w_gnt_char : 8'h00;

`ifdef ID_SCAN_TIMEOUT_EN
    assign fsm_en      = w_xfer | (state_q == ST_FLUSH);
    assign tok_abort   = tok_abort_q;
`else
    assign fsm_en      = w_xfer;
    assign tok_abort   = 1'b0;
`endif

    assign tok_done    = tok_done_q;
    assign tok_src     = tok_src_q;
    assign tok_match   = tok_match_q;
    assign match_cnt0  = cnt0_q;
    assign match_cnt1  = cnt1_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tok_done_d   = 1'b0;
        tok_src_d    = tok_src_q;
        tok_match_d  = tok_match_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
`ifdef ID_SCAN_TIMEOUT_EN
        stall_d      = stall_q;
        tok_abort_d  = tok_abort_q;
`endif

        // Counters advance during the result pulse itself.
        if (tok_done_q && tok_match_q) begin
            if (!tok_src_q && (cnt0_q != C_CNT_MAX)) cnt0_d = cnt0_q + 1'b1;
            if ( tok_src_q && (cnt1_q != C_CNT_MAX)) cnt1_d = cnt1_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (src0_valid || src1_valid) begin
                    grant_d      = w_pick;
                    last_grant_d = w_pick;
                    state_d      = ST_BUSY;
`ifdef ID_SCAN_TIMEOUT_EN
                    stall_d      = '0;
`endif
                end
            end

            ST_BUSY: begin
                if (w_xfer) begin
`ifdef ID_SCAN_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (w_term) begin
                        state_d     = ST_IDLE;
                        tok_done_d  = 1'b1;
                        tok_src_d   = grant_q;
                        tok_match_d = fsm_out;
`ifdef ID_SCAN_TIMEOUT_EN
                        tok_abort_d = 1'b0;
`endif
                    end
                end
`ifdef ID_SCAN_TIMEOUT_EN
                else begin
                    if (stall_q == C_STALL_LAST) state_d = ST_FLUSH;
                    stall_d = stall_q + 1'b1;
                end
`endif
            end

`ifdef ID_SCAN_TIMEOUT_EN
            ST_FLUSH: begin
                state_d     = ST_IDLE;
                tok_done_d  = 1'b1;
                tok_src_d   = grant_q;
                tok_match_d = 1'b0;
                tok_abort_d = 1'b1;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            tok_done_q   <= 1'b0;
            tok_src_q    <= 1'b0;
            tok_match_q  <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
`ifdef ID_SCAN_TIMEOUT_EN
            stall_q      <= '0;
            tok_abort_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tok_done_q   <= tok_done_d;
            tok_src_q    <= tok_src_d;
            tok_match_q  <= tok_match_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
`ifdef ID_SCAN_TIMEOUT_EN
            stall_q      <= stall_d;
            tok_abort_q  <= tok_abort_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_scan_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_id_scan_arbiter
// Purpose  : Two-source token traffic against an identifier-rule scoreboard
//            and a round-robin grant model; stand-in recognizer included.
// Revision : 1.0
// =============================================================================
module tb_id_scan_arbiter;

    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             src0_valid = 1'b0;
    logic [7:0]       src0_char = 8'h00;
    logic             src0_ready;
    logic             src1_valid = 1'b0;
    logic [7:0]       src1_char = 8'h00;
    logic             src1_ready;
    logic [7:0]       fsm_char;
    logic             fsm_en;
    logic             fsm_out;
    logic             tok_done;
    logic             tok_src;
    logic             tok_match;
    logic             tok_abort;
    logic [CNT_W-1:0] match_cnt0;
    logic [CNT_W-1:0] match_cnt1;

    always #5 clk = ~clk;

    id_scan_arbiter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .src0_valid (src0_valid),
        .src0_char  (src0_char),
        .src0_ready (src0_ready),
        .src1_valid (src1_valid),
        .src1_char  (src1_char),
        .src1_ready (src1_ready),
        .fsm_char   (fsm_char),
        .fsm_en     (fsm_en),
        .fsm_out    (fsm_out),
        .tok_done   (tok_done),
        .tok_src    (tok_src),
        .tok_match  (tok_match),
        .tok_abort  (tok_abort),
        .match_cnt0 (match_cnt0),
        .match_cnt1 (match_cnt1)
    );

    function automatic bit is_alpha(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    function automatic bit is_alnum(input logic [7:0] c);
        return is_alpha(c) || ((c >= 8'h30) && (c <= 8'h39));
    endfunction

    // Stand-in recognizer: 0 = start, 1 = inside identifier, 2 = rejected.
    logic [1:0] r_rec_q;
    always_ff @(posedge clk) begin
        if (reset)                 r_rec_q <= 2'd0;
        else if (fsm_en) begin
            if (!is_alnum(fsm_char)) r_rec_q <= 2'd0;
            else if (r_rec_q == 2'd0) r_rec_q <= is_alpha(fsm_char) ? 2'd1 : 2'd2;
        end
    end
    assign fsm_out = (r_rec_q == 2'd1);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else             n_pass++;
    endtask

    // Scoreboard state
    logic [7:0] drv0[$];
    logic [7:0] drv1[$];
    bit         res0[$];
    bit         res1[$];
    int         served[$];
    int         plen[2];
    logic [7:0] pfirst[2];
    int         gap_pct  = 0;
    bit         model_on = 1'b1;

    bit         x0, x1, p_reset, p_term, pend, pend_src, pend_res, cnt_chk, m_last, g;
    logic [1:0] p_r, p_v, p_x, e_rdy;
    int         m_cnt0, m_cnt1;

    task automatic send_char(input int s, input logic [7:0] c);
        bit r;
        if (s == 0) drv0.push_back(c);
        else        drv1.push_back(c);
        if (is_alnum(c)) begin
            if (plen[s] == 0) pfirst[s] = c;
            plen[s]++;
        end else begin
            r = (plen[s] > 0) && is_alpha(pfirst[s]);
            if (s == 0) res0.push_back(r);
            else        res1.push_back(r);
            plen[s] = 0;
        end
    endtask

    task automatic send(input int s, input string str);
        for (int i = 0; i < str.len(); i++) send_char(s, str[i]);
    endtask

    task automatic send_rand(input int s);
        int         len;
        logic [7:0] c;
        len = $urandom_range(0, 5);
        for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 2))
                0:       c = 8'h61 + 8'($urandom_range(0, 25));
                1:       c = 8'h41 + 8'($urandom_range(0, 25));
                default: c = 8'h30 + 8'($urandom_range(0, 9));
            endcase
            send_char(s, c);
        end
        do c = 8'($urandom_range(0, 255)); while (is_alnum(c));
        send_char(s, c);
    endtask

    // Source drivers: pop on observed transfer, then present the next byte.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (x0 && drv0.size() > 0) void'(drv0.pop_front());
            if (x1 && drv1.size() > 0) void'(drv1.pop_front());
            if (drv0.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                src0_valid = 1'b1; src0_char = drv0[0];
            end else begin
                src0_valid = 1'b0; src0_char = 8'($urandom);
            end
            if (drv1.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                src1_valid = 1'b1; src1_char = drv1[0];
            end else begin
                src1_valid = 1'b0; src1_char = 8'($urandom);
            end
        end
    end

    // Monitor: grant model, transfer rules and token results every cycle.
    initial begin
        forever begin
            @(negedge clk);
            x0 = src0_valid & src0_ready;
            x1 = src1_valid & src1_ready;
            if (reset) begin
                x0 = 1'b0; x1 = 1'b0;
                p_reset = 1'b1; pend = 1'b0; cnt_chk = 1'b0; m_last = 1'b1;
                m_cnt0 = 0; m_cnt1 = 0; p_r = '0; p_v = '0; p_x = '0; p_term = 1'b0;
            end else begin
                if (model_on) begin
                    if (p_reset) e_rdy = 2'b00;
                    else if (p_r == 2'b00) begin
                        if (p_v != 2'b00) begin
                            g      = (p_v == 2'b11) ? ~m_last : p_v[1];
                            m_last = g;
                            e_rdy  = g ? 2'b10 : 2'b01;
                        end else e_rdy = 2'b00;
                    end else e_rdy = ((p_x != 2'b00) && p_term) ? 2'b00 : p_r;
                    check("ready", {src1_ready, src0_ready}, e_rdy);
                    check("fsm_en", fsm_en, x0 | x1);
                    if (x0 | x1) check("fsm_char", fsm_char, x1 ? src1_char : src0_char);
                    if (cnt_chk) begin
                        check("cnt0", match_cnt0, m_cnt0);
                        check("cnt1", match_cnt1, m_cnt1);
                        cnt_chk = 1'b0;
                    end
                    check("tok_done", tok_done, pend);
                    if (pend && tok_done) begin
                        check("tok_src", tok_src, pend_src);
                        check("tok_match", tok_match, pend_res);
                        check("tok_abort", tok_abort, 0);
                        served.push_back(int'(tok_src));
                        if (pend_res && !pend_src && m_cnt0 < CNT_MAX) m_cnt0++;
                        if (pend_res &&  pend_src && m_cnt1 < CNT_MAX) m_cnt1++;
                        cnt_chk = 1'b1;
                    end
                    pend = (x0 | x1) && !is_alnum(x1 ? src1_char : src0_char);
                    if (pend) begin
                        pend_src = x1;
                        if (x1 ? (res1.size() > 0) : (res0.size() > 0))
                            pend_res = x1 ? res1.pop_front() : res0.pop_front();
                        else begin
                            check("res_underflow", 1, 0);
                            pend_res = 1'b0;
                        end
                    end
                end
                p_reset = 1'b0;
                p_r     = {src1_ready, src0_ready};
                p_v     = {src1_valid, src0_valid};
                p_x     = {x1, x0};
                p_term  = !is_alnum(x1 ? src1_char : src0_char);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        drv0.delete(); drv1.delete(); res0.delete(); res1.delete();
        plen[0] = 0; plen[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tok",  {tok_done, tok_src, tok_match, tok_abort}, 0);
        check("rst_cnt",  {match_cnt1, match_cnt0}, 0);
        check("rst_rdy",  {src1_ready, src0_ready, fsm_en}, 0);
        check("rst_char", fsm_char, 0);
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (drv0.size() + drv1.size() != 0) begin
            @(posedge clk); #2;
            n++;
            if (n > 20000) begin check("drain_timeout", 1, 0); break; end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((drv0.size() + drv1.size() + res0.size() + res1.size()) != 0 || pend) begin
            @(posedge clk); #2;
            n++;
            if (n > 20000) begin check("idle_timeout", 1, 0); break; end
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        send(0, "abcd1234/");
        wait_idle();
        check("t1_src", tok_src, 0);
        check("t1_match", tok_match, 1);
        check("t1_cnt0", match_cnt0, 1);
        check("t1_cnt1", match_cnt1, 0);

        send(1, "1ab/");
        wait_idle();
        check("t2_src", tok_src, 1);
        check("t2_match", tok_match, 0);
        check("t2_cnt1", match_cnt1, 0);

        do_reset();
        served.delete();
        for (int i = 0; i < 2; i++) begin
            send(0, "ab1/");
            send(1, "ab1/");
        end
        wait_idle();
        check("alt_count", served.size(), 4);
        for (int i = 0; i < served.size(); i++) check("alt_src", served[i], i % 2);
        check("alt_cnt0", match_cnt0, 2);
        check("alt_cnt1", match_cnt1, 2);

        do_reset();
        for (int k = 1; k <= 5; k++) begin
            send(0, "x9/");
            wait_idle();
            check("sat_cnt0", match_cnt0, (k < CNT_MAX) ? k : CNT_MAX);
        end

        do_reset();
        send(0, "ab");
        wait_drain();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("gap_en", fsm_en, 0);
            check("gap_rdy", src0_ready, 1);
        end
        @(posedge clk); #2;
        send(0, "1/");
        wait_idle();
        check("gap_src", tok_src, 0);
        check("gap_match", tok_match, 1);

        send(0, "ab");
        wait_drain();
        repeat (2) @(posedge clk);
        do_reset();
        send(1, "z/");
        wait_idle();
        check("post_rst_src", tok_src, 1);
        check("post_rst_match", tok_match, 1);

        do_reset();
        gap_pct = 30;
        for (int i = 0; i < 150; i++) begin
            send_rand(0);
            send_rand(1);
        end
        wait_idle();
        gap_pct = 0;

`ifdef ID_SCAN_TIMEOUT_EN
        do_reset();
        model_on = 1'b0;
        send(1, "ab");
        begin
            int stall;
            bit flush_seen, got_abort, got_src0, sent0;
            stall = 0; flush_seen = 0; got_abort = 0; got_src0 = 0; sent0 = 0;
            for (int i = 0; i < 200 && !got_src0; i++) begin
                @(negedge clk);
                if (src1_ready && !sent0) begin send(0, "ab/"); sent0 = 1'b1; end
                if (src1_ready && !src1_valid) stall++;
                if (fsm_en && fsm_char == 8'h00 && !src0_ready && !src1_ready) flush_seen = 1'b1;
                if (tok_done && !got_abort) begin
                    check("to_src", tok_src, 1);
                    check("to_abort", tok_abort, 1);
                    check("to_match", tok_match, 0);
                    check("to_flush", flush_seen, 1);
                    check("to_stall", stall, TIMEOUT);
                    got_abort = 1'b1;
                end else if (tok_done) begin
                    check("to_next_src", tok_src, 0);
                    check("to_next_match", tok_match, 1);
                    check("to_next_abort", tok_abort, 0);
                    got_src0 = 1'b1;
                end
            end
            check("to_done", got_src0, 1);
            check("to_cnt1", match_cnt1, 0);
        end
        do_reset();
        model_on = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
